mul_job_sequencer: RTL and testbench
====================================

MUL_JOB_SEQUENCER -- requirements
Module: mul_job_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4; operand-pair FIFO entries (power of 2, >=2).
REQ-002 Parameter TIMEOUT, default 15; maximum WAIT cycles before a job is aborted (1..255).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers operand pair.
REQ-006 in_ready  output  1  FIFO not full; transfer occurs when in_valid&in_ready at a rising edge.
REQ-007 in_a, in_b  input  4 each  multiplicand, multiplier.
REQ-008 mul_start  output  1  one-cycle start pulse to the add-shift multiplier.
REQ-009 mul_a, mul_b  output  4 each  operands driven to the multiplier.
REQ-010 mul_ready  input  1  multiplier done flag; stays high while the multiplier is idle in its done state.
REQ-011 mul_product  input  8  multiplier result.
REQ-012 out_valid  output  1  result slot full.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid&out_ready at a rising edge.
REQ-014 out_a, out_b  output  4 each; out_product  output  8  job operands and product.
REQ-015 timeout_err  output  1  one-cycle pulse when a job is aborted.
REQ-016 jobs_done  output  8  count of results written to the slot, wraps 255->0.

Function
REQ-017 FIFO: FIFO_DEPTH x 8 bits {a,b}; in_ready = !full; push on in handshake; pop on ISSUE; simultaneous push and pop when full is not allowed (in_ready low); when empty, push and pop cannot coincide (ISSUE requires non-empty at state entry).
REQ-018 FSM states IDLE, ISSUE, GUARD, WAIT.
REQ-019 IDLE -> ISSUE when FIFO non-empty and result slot empty (or emptying this cycle via out handshake); otherwise stay.
REQ-020 ISSUE: mul_start=1 for exactly this cycle; FIFO head latched into mul_a/mul_b and popped; -> GUARD.
REQ-021 mul_a/mul_b hold constant from ISSUE until the next ISSUE.
REQ-022 GUARD: mul_ready ignored (may still be high from previous job); wait counter cleared; -> WAIT.
REQ-023 WAIT: on mul_ready=1, capture mul_product, mul_a, mul_b into the result slot, set out_valid, increment jobs_done -> IDLE.
REQ-024 WAIT: wait counter increments each cycle mul_ready=0; when counter reaches TIMEOUT, pulse timeout_err, drop job (slot unchanged, jobs_done unchanged) -> IDLE.
REQ-025 Minimum throughput: one job per (latency of multiplier + 3) cycles; no back-to-back start pulses.
REQ-026 out_valid clears on out handshake unless a new capture occurs in the same cycle (cannot occur per REQ-019, so it clears).
REQ-027 Result slot contents stable while out_valid=1 and out_ready=0.
REQ-028 mul_start never asserted while result slot is full and not being emptied.

Reset
REQ-029 reset (synchronous) overrides all: state=IDLE, FIFO empty (in_ready=1 the cycle after reset releases), out_valid=0, out_a/out_b/out_product=0, mul_start=0, mul_a/mul_b=0, timeout_err=0, jobs_done=0.
REQ-030 Reset during GUARD/WAIT abandons the in-flight job without timeout_err; a mul_ready arriving after reset is ignored.

Structure
REQ-031 Shared package holds the state encoding (IDLE=0, ISSUE=1, GUARD=2, WAIT=3) and default FIFO_DEPTH/TIMEOUT constants.
REQ-032 FIFO is a separate sub-module, op_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-033 Single job a=14, b=5, behavioural multiplier with 5-cycle latency -> one mul_start pulse, out_valid with out_product=70 (0x46), out_a=14, out_b=5, jobs_done=1.
REQ-034 Push 5 pairs back-to-back with mul_ready held low before the first ISSUE -> in_ready low after the FIFO holds 4 entries, 5th push stalls until first ISSUE pop.
REQ-035 out_ready=0 with 3 queued jobs -> first result held stable, no second mul_start until out handshake; all 3 products delivered in order (e.g. 3*3=9, 15*15=225, 0*7=0).
REQ-036 mul_ready held 0 after start -> timeout_err pulse exactly TIMEOUT cycles after entering WAIT, out_valid stays 0, jobs_done unchanged, next job issued.
REQ-037 mul_ready stuck 1 from prior job -> GUARD prevents capture at GUARD cycle; capture only in first WAIT cycle with mul_ready=1 after start.
REQ-038 reset asserted mid-WAIT -> all outputs at reset values next cycle, FIFO empty, late mul_ready produces no out_valid.

Source files
------------

// File: rtl/mul_job_sequencer_pkg.sv
// Shared types and defaults for the multiplier job sequencer.
package mul_job_sequencer_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned DEFAULT_TIMEOUT    = 15;
    localparam int unsigned OP_W               = 4;
    localparam int unsigned PROD_W             = 8;
    localparam int unsigned CNT_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mul_job_sequencer_op_fifo.sv
// Operand-pair FIFO with registered full/empty flags and a combinational head view.
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata_c = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flags are computed from the next occupancy so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

endmodule

// File: rtl/mul_job_sequencer.sv
// Feeds queued operand pairs to an add-shift multiplier one job at a time and
// collects each product into a single-entry result slot, aborting stalled jobs.
module mul_job_sequencer
    import mul_job_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic       mul_ready,
    input  logic [7:0] mul_product,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [7:0] out_product,
    output logic       timeout_err,
    output logic [7:0] jobs_done
);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    op_pair_t         push_pair;
    op_pair_t         head_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             slot_free;

    assign push_pair = '{a: in_a, b: in_b};
    assign in_ready  = ~fifo_full;
    assign fifo_pop  = (state == ST_ISSUE);
    assign slot_free = ~out_valid | out_ready;

    op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(op_pair_t))
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .pop     (fifo_pop),
        .wdata   (push_pair),
        .rdata_c (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Operands are latched on entry to ISSUE so they are valid alongside the start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_product <= '0;
            timeout_err <= 1'b0;
            jobs_done   <= '0;
        end else begin
            mul_start   <= 1'b0;
            timeout_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && slot_free) begin
                        state     <= ST_ISSUE;
                        mul_start <= 1'b1;
                        mul_a     <= head_c.a;
                        mul_b     <= head_c.b;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_GUARD;
                end
                // mul_ready may still reflect the previous job here.
                ST_GUARD: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_ready) begin
                        out_valid   <= 1'b1;
                        out_a       <= mul_a;
                        out_b       <= mul_b;
                        out_product <= mul_product;
                        jobs_done   <= jobs_done + 8'd1;
                        state       <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Scoreboard bench for mul_job_sequencer with a behavioural add-shift multiplier.
module tb_mul_job_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_ready;
    logic       mul_start;
    logic [3:0] mul_a, mul_b;
    logic       mul_ready = 1'b1;
    logic [7:0] mul_product = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_a, out_b;
    logic [7:0] out_product;
    logic       timeout_err;
    logic [7:0] jobs_done;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    logic [7:0]  in_q[$];
    logic [15:0] out_q[$];
    int          exp_to = -1;
    int          exp_jobs = 0;
    int          start_cnt = 0;
    int          to_cnt = 0;
    logic [7:0]  last_prod = '0;
    logic        prev_start, prev_ov, prev_ordy;
    logic [3:0]  prev_ma, prev_mb, prev_oa, prev_ob;
    logic [7:0]  prev_op;

    // Controls
    bit rand_en = 0, rand_out = 0, force_hang = 0, sticky_force = 0;
    bit out_ready_force = 0, force_done = 0;
    bit nx_hang = 0, nx_sticky = 0;
    int nx_lat = 5;

    // Multiplier model state
    logic [3:0] m_a = '0, m_b = '0;
    int         busy = 0;
    bit         hanging = 0;

    always #5 clk = ~clk;

    mul_job_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_product (out_product),
        .timeout_err (timeout_err),
        .jobs_done   (jobs_done)
    );

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier: done flag high when idle; optionally keeps a stale done for one cycle.
    always @(posedge clk) begin
        if (mul_start) begin
            m_a <= mul_a;
            m_b <= mul_b;
            if (!nx_sticky) mul_ready <= 1'b0;
            busy    <= nx_hang ? 0 : nx_lat;
            hanging <= nx_hang;
        end else if (force_done) begin
            hanging     <= 1'b0;
            busy        <= 0;
            mul_ready   <= 1'b1;
            mul_product <= 8'hA5;
        end else if (hanging) begin
            mul_ready <= 1'b0;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                mul_ready   <= 1'b1;
                mul_product <= prod(m_a, m_b);
            end else begin
                mul_ready <= 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_out ? ($urandom_range(0, 2) != 0) : out_ready_force;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0]  j;
        logic [15:0] r;
        cyc++;
        if (reset) begin
            in_q.delete();
            out_q.delete();
            exp_to = -1;
            exp_jobs = 0;
            prev_start = 0; prev_ov = 0; prev_ordy = 0;
            prev_ma = '0; prev_mb = '0; prev_oa = '0; prev_ob = '0; prev_op = '0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(in_q.size() < DEPTH));
            chk("timeout_err", 32'(timeout_err), 32'(cyc == exp_to));
            if (cyc == exp_to) begin
                chk("timeout_out_valid", 32'(out_valid), 0);
                chk("timeout_jobs_done", 32'(jobs_done), 32'(exp_jobs % 256));
                to_cnt++;
                exp_to = -1;
            end
            if (mul_start) begin
                start_cnt++;
                chk("back_to_back_start", 32'(prev_start), 0);
                chk("start_while_slot_full", 32'(out_valid), 0);
                if (in_q.size() == 0) begin
                    chk("start_without_job", 1, 0);
                end else begin
                    j = in_q.pop_front();
                    chk("mul_a", 32'(mul_a), 32'(j[7:4]));
                    chk("mul_b", 32'(mul_b), 32'(j[3:0]));
                    nx_hang   = force_hang || (rand_en && $urandom_range(0, 7) == 0);
                    nx_sticky = rand_en ? ($urandom_range(0, 1) == 1) : sticky_force;
                    nx_lat    = rand_en ? int'($urandom_range(1, 6)) : 5;
                    if (nx_hang) exp_to = cyc + 2 + int'(TO);
                    else begin
                        exp_jobs++;
                        out_q.push_back({j, prod(j[7:4], j[3:0])});
                    end
                end
            end else begin
                chk("mul_a_hold", 32'(mul_a), 32'(prev_ma));
                chk("mul_b_hold", 32'(mul_b), 32'(prev_mb));
            end
            if (out_valid && !prev_ov) begin
                chk("jobs_done_at_capture", 32'(jobs_done), 32'(exp_jobs % 256));
                if (out_q.size() == 0) chk("spurious_out_valid", 1, 0);
            end
            if (prev_ov && !prev_ordy) begin
                chk("slot_held_valid", 32'(out_valid), 1);
                chk("slot_held_a", 32'(out_a), 32'(prev_oa));
                chk("slot_held_b", 32'(out_b), 32'(prev_ob));
                chk("slot_held_product", 32'(out_product), 32'(prev_op));
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    chk("handshake_without_job", 1, 0);
                end else begin
                    r = out_q.pop_front();
                    chk("out_a", 32'(out_a), 32'(r[15:12]));
                    chk("out_b", 32'(out_b), 32'(r[11:8]));
                    chk("out_product", 32'(out_product), 32'(r[7:0]));
                    last_prod = out_product;
                end
            end
            if (in_valid && in_ready) in_q.push_back({in_a, in_b});
            prev_start = mul_start; prev_ov = out_valid; prev_ordy = out_ready;
            prev_ma = mul_a; prev_mb = mul_b;
            prev_oa = out_a; prev_ob = out_b; prev_op = out_product;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("push_accept", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            ok = (in_q.size() == 0) && (out_q.size() == 0) && (exp_to < 0) && !out_valid && !mul_start;
        end
        if (!ok) chk("idle_wait", 0, 1);
    endtask

    task automatic wait_start(input int s0);
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            tick();
            ok = start_cnt > s0;
        end
        if (!ok) chk("start_wait", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_a"}, 32'(out_a), 0);
        chk({tag, "_out_b"}, 32'(out_b), 0);
        chk({tag, "_out_product"}, 32'(out_product), 0);
        chk({tag, "_mul_start"}, 32'(mul_start), 0);
        chk({tag, "_mul_a"}, 32'(mul_a), 0);
        chk({tag, "_mul_b"}, 32'(mul_b), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_jobs_done"}, 32'(jobs_done), 0);
    endtask

    initial begin
        int  s0, t0;
        bit  ok;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Single job 14*5
        out_ready_force = 1;
        repeat (2) tick();
        push_job(4'd14, 4'd5);
        wait_idle(100);
        chk("single_starts", 32'(start_cnt), 1);
        chk("single_jobs_done", 32'(jobs_done), 1);
        chk("single_product", 32'(last_prod), 32'h46);

        // Stale done flag held through GUARD
        sticky_force = 1;
        push_job(4'd9, 4'd7);
        wait_idle(100);
        sticky_force = 0;
        chk("guard_product", 32'(last_prod), 63);
        chk("guard_jobs_done", 32'(jobs_done), 2);

        // Backpressure: slot held, FIFO fills, fifth push stalls
        out_ready_force = 0;
        repeat (2) tick();
        push_job(4'd3, 4'd3);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            ok = out_valid;
        end
        if (!ok) chk("first_result_wait", 0, 1);
        s0 = start_cnt;
        push_job(4'd15, 4'd15);
        push_job(4'd0, 4'd7);
        push_job(4'd6, 4'd9);
        push_job(4'd11, 4'd2);
        @(negedge clk);
        chk("fifo_full_in_ready", 32'(in_ready), 0);
        fork
            push_job(4'd1, 4'd1);
            begin
                repeat (8) tick();
                chk("fifth_push_stalled", 32'(in_q.size()), 4);
                chk("no_start_while_held", 32'(start_cnt), 32'(s0));
                chk("first_result_held", 32'(out_product), 9);
                out_ready_force = 1;
            end
        join
        wait_idle(300);
        chk("backpressure_jobs_done", 32'(jobs_done), 8);
        chk("backpressure_last", 32'(last_prod), 1);

        // Timeout then next job
        force_hang = 1;
        s0 = start_cnt;
        t0 = to_cnt;
        push_job(4'd2, 4'd3);
        wait_start(s0);
        force_hang = 0;
        push_job(4'd4, 4'd4);
        wait_idle(200);
        chk("timeout_count", 32'(to_cnt), 32'(t0 + 1));
        chk("timeout_jobs_done", 32'(jobs_done), 9);
        chk("after_timeout_product", 32'(last_prod), 16);

        // Randomised traffic
        rand_en = 1;
        rand_out = 1;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        rand_out = 0;
        wait_idle(3000);
        rand_en = 0;
        chk("random_jobs_done", 32'(jobs_done), 32'(exp_jobs % 256));

        // Reset during WAIT, late done ignored
        force_hang = 1;
        s0 = start_cnt;
        push_job(4'd5, 4'd5);
        wait_start(s0);
        force_hang = 0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_wait_reset");
        tick();
        force_done = 1;
        tick();
        force_done = 0;
        repeat (25) tick();
        chk("late_ready_out_valid", 32'(out_valid), 0);
        chk("late_ready_jobs_done", 32'(jobs_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
